imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_loader.sv | 132 +++++++++++++
 tb/tb_imem_loader.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCheck,
    StDrain,
    StRun,
    StError
  } loader_state_t;

  localparam int unsigned IMEM_WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader.sv
// Streams a host program image into instruction memory and holds the core in reset meanwhile.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing modulo-2^32 checksum beat per image.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  localparam int unsigned CNT_W      = $clog2(DEPTH_WORDS) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic [CNT_W-1:0] load_len,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  output logic             s_ready,
  output logic             imem_wr_en,
  output logic [31:0]      imem_wr_addr,
  output logic [31:0]      imem_wr_data,
  output logic             core_hold,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);

  loader_state_t    state_q;
  loader_state_t    start_state;
  logic [CNT_W-1:0] len_q;
  logic             start_take;
  logic             beat;
  logic             last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]      sum_q;
`endif

  // A new load is only honoured while no image is in flight.
  always_comb begin
    start_take = load_start &&
                 ((state_q == StIdle) || (state_q == StRun) || (state_q == StError));
    if (load_len == '0) begin
      start_state = StRun;
    end else if (load_len > CNT_W'(DEPTH_WORDS)) begin
      start_state = StError;
    end else begin
      start_state = StLoad;
    end
  end

  assign beat      = s_valid && s_ready;
  // words_loaded doubles as the write index: both count accepted image words.
  assign last_word = (words_loaded == len_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      len_q        <= '0;
      s_ready      <= 1'b0;
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= BASE_ADDR;
      imem_wr_data <= '0;
      core_hold    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      imem_wr_en <= 1'b0;
      if (start_take) begin
        state_q      <= start_state;
        len_q        <= load_len;
        words_loaded <= '0;
        s_ready      <= (start_state == StLoad);
        busy         <= (start_state == StLoad);
        core_hold    <= (start_state != StRun);
        done         <= (start_state == StRun);
        error        <= (start_state == StError);
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_q        <= '0;
`endif
      end else begin
        case (state_q)
          StLoad: begin
            if (beat) begin
              imem_wr_en   <= 1'b1;
              imem_wr_addr <= BASE_ADDR + 32'(words_loaded) * IMEM_WORD_BYTES;
              imem_wr_data <= s_data;
              words_loaded <= words_loaded + CNT_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
              sum_q        <= sum_q + s_data;
              if (last_word) begin
                state_q <= StCheck;
              end
`else
              if (last_word) begin
                state_q <= StDrain;
                s_ready <= 1'b0;
              end
`endif
            end
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          StCheck: begin
            // The checksum beat is consumed but never written to memory.
            if (beat) begin
              s_ready <= 1'b0;
              if (s_data == sum_q) begin
                state_q <= StDrain;
              end else begin
                state_q <= StError;
                error   <= 1'b1;
                busy    <= 1'b0;
              end
            end
          end
`endif
          StDrain: begin
            state_q   <= StRun;
            busy      <= 1'b0;
            core_hold <= 1'b0;
            done      <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader; expected writes come from the image model.
module tb_imem_loader;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start;
  logic [CW-1:0] load_len;
  logic          s_valid;
  logic [31:0]   s_data;
  logic          s_ready;
  logic          imem_wr_en;
  logic [31:0]   imem_wr_addr;
  logic [31:0]   imem_wr_data;
  logic          core_hold;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW-1:0] words_loaded;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  logic [31:0] fixed_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  imem_loader #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .load_len    (load_len),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .imem_wr_en  (imem_wr_en),
    .imem_wr_addr(imem_wr_addr),
    .imem_wr_data(imem_wr_data),
    .core_hold   (core_hold),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (imem_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write (t=%0t)",
                 imem_wr_addr, imem_wr_data, $time);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", {32'h0, imem_wr_addr}, {32'h0, e.addr});
        chk("wr_data", {32'h0, imem_wr_data}, {32'h0, e.data});
      end
    end
  end

  task automatic pulse_start(input int len);
    @(negedge clk);
    load_start = 1'b1;
    load_len   = CW'(len);
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // mode: 0 back-to-back, 1 valid every other cycle, 2 random valid plus stray load_start.
  task automatic do_load(input int len, input int mode, input bit bad_sum);
    logic [31:0] words[$];
    logic [31:0] sum;
    int          idx;
    int          cyc;
    bit          acc;
    sum = '0;
    for (int i = 0; i < len; i++) begin
      words.push_back((fixed_q.size() > 0) ? fixed_q[i] : $urandom);
      sb.push_back('{addr: BASE + 32'(i) * 4, data: words[i]});
      sum = sum + words[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    words.push_back(bad_sum ? sum + 32'd1 : sum);
`endif
    pulse_start(len);
    chk("start_s_ready", {63'h0, s_ready}, 64'd1);
    chk("start_busy", {63'h0, busy}, 64'd1);
    chk("start_core_hold", {63'h0, core_hold}, 64'd1);
    chk("start_done", {63'h0, done}, 64'd0);
    idx = 0;
    cyc = 0;
    while (idx < words.size() && cyc < 4000) begin
      s_valid    = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      s_data     = s_valid ? words[idx] : $urandom;
      load_start = (mode == 2) && ($urandom_range(0, 7) == 0);
      load_len   = '0;
      acc        = s_valid && s_ready;
      @(posedge clk);
      if (acc) idx++;
      cyc++;
      @(negedge clk);
    end
    s_valid    = 1'b0;
    load_start = 1'b0;
    chk("stream_complete", 64'(idx), 64'(words.size()));
    if (!bad_sum) begin
      chk("drain_core_hold", {63'h0, core_hold}, 64'd1);
      chk("drain_busy", {63'h0, busy}, 64'd1);
      chk("drain_s_ready", {63'h0, s_ready}, 64'd0);
      @(negedge clk);
      chk("run_core_hold", {63'h0, core_hold}, 64'd0);
      chk("run_done", {63'h0, done}, 64'd1);
      chk("run_busy", {63'h0, busy}, 64'd0);
      chk("run_error", {63'h0, error}, 64'd0);
      chk("words_loaded", 64'(words_loaded), 64'(len));
    end else begin
      chk("badsum_error", {63'h0, error}, 64'd1);
      chk("badsum_core_hold", {63'h0, core_hold}, 64'd1);
      chk("badsum_busy", {63'h0, busy}, 64'd0);
      chk("badsum_done", {63'h0, done}, 64'd0);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_core_hold", {63'h0, core_hold}, 64'd1);
    chk("rst_s_ready", {63'h0, s_ready}, 64'd0);
    chk("rst_wr_en", {63'h0, imem_wr_en}, 64'd0);
    chk("rst_wr_addr", {32'h0, imem_wr_addr}, {32'h0, BASE});
    chk("rst_wr_data", {32'h0, imem_wr_data}, 64'd0);
    chk("rst_busy", {63'h0, busy}, 64'd0);
    chk("rst_done", {63'h0, done}, 64'd0);
    chk("rst_error", {63'h0, error}, 64'd0);
    chk("rst_words_loaded", 64'(words_loaded), 64'd0);
  endtask

  initial begin
    reset      = 1'b1;
    load_start = 1'b0;
    load_len   = '0;
    s_valid    = 1'b0;
    s_data     = '0;
    repeat (3) @(negedge clk);
    chk_reset_values();
    reset = 1'b0;

    // Basic three-instruction image.
    fixed_q = '{32'h00500093, 32'h00A00113, 32'h002081B3};
    do_load(3, 0, 1'b0);
    fixed_q.delete();

    do_load(4, 1, 1'b0);

    // Oversized image is rejected without writes; host traffic must be ignored.
    pulse_start(DEPTH + 1);
    chk("badlen_error", {63'h0, error}, 64'd1);
    chk("badlen_core_hold", {63'h0, core_hold}, 64'd1);
    chk("badlen_busy", {63'h0, busy}, 64'd0);
    chk("badlen_s_ready", {63'h0, s_ready}, 64'd0);
    s_valid = 1'b1;
    repeat (4) @(negedge clk);
    s_valid = 1'b0;

    // Zero length boots existing contents; then hot reload.
    pulse_start(0);
    chk("zero_done", {63'h0, done}, 64'd1);
    chk("zero_core_hold", {63'h0, core_hold}, 64'd0);
    chk("zero_error", {63'h0, error}, 64'd0);
    repeat (2) @(negedge clk);
    do_load(2, 0, 1'b0);

    // Reset after 2 of 5 beats.
    for (int i = 0; i < 5; i++) sb.push_back('{addr: BASE + 32'(i) * 4, data: 32'(i + 100)});
    pulse_start(5);
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data  = 32'(i + 100);
      @(negedge clk);
    end
    s_valid = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_values();
    chk("midload_pending", 64'(sb.size()), 64'd3);
    sb.delete();
    do_load(3, 0, 1'b0);

    for (int it = 0; it < 8; it++) begin
      do_load(int'($urandom_range(1, 20)), int'($urandom_range(0, 2)), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Full-depth image exercises the highest word address.
    do_load(DEPTH, 0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    fixed_q = '{32'd1, 32'd2, 32'd3};
    do_load(3, 0, 1'b0);
    do_load(3, 0, 1'b1);
    fixed_q.delete();
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
